addsub_serial_checker: RTL and testbench
========================================

// Module: addsub_serial_checker
// PURPOSE
//  Response end of the 8-bit CLA add/sub interface: accepts an operand vector {A,B,op} together with the
//  CLA's combinational answer {S,cout}, recomputes the reference result with a bit-serial adder, and flags mismatches.
//  Used in the Mini-8-bit-CPU as an on-chip self-check beside the ALU adder; also reused as the bench scoreboard.
// PARAMETERS
//  WIDTH      8   operand/sum width in bits
//  ERR_CNT_W  8   width of saturating mismatch counter
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          synchronous, active-low reset
//  in_valid   in   1          vector + DUT answer presented
//  in_ready   out  1          block can accept a vector (IDLE)
//  a          in   WIDTH      operand A
//  b          in   WIDTH      operand B
//  op         in   1          0 = A+B, 1 = A-B (A + ~B + 1)
//  dut_s      in   WIDTH      CLA sum under check
//  dut_cout   in   1          CLA carry-out under check
//  chk_valid  out  1          one-cycle pulse: check result available
//  chk_pass   out  1          1 = {dut_cout,dut_s} equals expected (valid with chk_valid)
//  exp_s      out  WIDTH      expected sum (held until next check)
//  exp_cout   out  1          expected carry-out (held)
//  err_count  out  ERR_CNT_W  saturating count of failed checks
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): state IDLE; in_ready=1; chk_valid=0, chk_pass=0, exp_s=0, exp_cout=0, err_count=0.
//  - Handshake: transfer when in_valid && in_ready at clk edge; a,b,op,dut_s,dut_cout all captured that edge.
//    in_ready=0 outside IDLE; in_valid while busy is ignored (no queueing).
//  - States: IDLE -> SHIFT (accept) -> SHIFT for WIDTH cycles -> CMP -> IDLE.
//    SHIFT: bit i = a[i] ^ (b[i]^op) ^ c; carry flop initialised to op at accept; LSB first, one bit/cycle.
//    CMP: latch exp_s/exp_cout, compare with captured DUT answer, assert chk_valid for exactly 1 cycle.
//  - Latency: accept at edge 0 -> chk_valid high in cycle after edge WIDTH+1; in_ready returns with chk_valid
//    (back-to-back accept allowed in the chk_valid cycle). Throughput 1 vector / WIDTH+2 cycles.
//  - Arithmetic: modulo 2^WIDTH; exp_cout = raw carry out of MSB (subtract: 1 = no borrow). No signed overflow flag.
//  - err_count += 1 on chk_valid && !chk_pass; saturates at all-ones, never wraps.
//  - Reset mid-operation: aborts current vector, no chk_valid, counter cleared.
//  - exp_s/exp_cout/chk_pass hold last values between checks; only chk_valid qualifies them.
// CONFIGURATION
//  ADDSUB_CHK_LOG_EN defined: adds outputs fail_a, fail_b (WIDTH), fail_op (1), fail_seen (1); first failing
//    vector captured at its CMP cycle and frozen until reset; fail_seen=1 thereafter. All reset to 0.
//  Not defined: those ports and registers are absent; remaining behaviour identical.
// STRUCTURE
//  Shared package addsub_pkg: state enum {IDLE,SHIFT,CMP}, OP_ADD=1'b0 / OP_SUB=1'b1, default WIDTH.
//  Sub-module serial_fa_bit: one full-adder cell with carry flop (clk, rst_n, load, cin_init, a, b, s).
//  Top: FSM, bit counter ($clog2(WIDTH+1) bits), operand/answer shift registers, compare + error counter.
// TESTING
//  1) a=01,b=01,op=1, dut 00/cout1 -> after 10 cycles chk_valid, exp_s=00, exp_cout=1, pass=1.
//  2) a=02,b=03,op=0 dut 05/0 -> pass; a=81,b=81,op=0 dut 02/1 -> pass; a=FF,b=01,op=0 dut 00/1 -> pass.
//  3) a=FF,b=00,op=1 dut FF/1 -> pass; a=FF,b=FF,op=0 dut FE/1 -> pass; err_count stays 0.
//  4) a=02,b=03,op=0 with dut_s=06 -> chk_pass=0, exp_s=05, err_count=1; LOG_EN: fail_a=02, fail_b=03, fail_seen=1.
//  5) Force 300 mismatches (ERR_CNT_W=8) -> err_count saturates at FF; in_valid while busy -> not accepted, no extra check.
//  6) rst_n=0 during SHIFT cycle 4 -> no chk_valid, in_ready=1 next cycle, err_count=0; next vector checks correctly.

Source files
------------

// File: rtl/addsub_pkg.sv
// ---------------------------------------------------------------------------
// Package: addsub_pkg
// Shared definitions for the serial add/sub checker: FSM state encoding,
// operation codes and the default operand width.
// ---------------------------------------------------------------------------
package addsub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CMP   = 2'd2
  } state_t;

endpackage

// File: rtl/addsub_serial_checker_fa_bit.sv
// ---------------------------------------------------------------------------
// Module: serial_fa_bit
// One full-adder cell with a carry flop. It is the datapath of a bit-serial
// adder, consuming one bit pair per clock, LSB first.
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   synchronous active-low reset (clears the carry)
//   load     in   preload the carry with cin_init instead of advancing
//   cin_init in   carry-in for bit 0 (1 for subtract)
//   a, b     in   current operand bits
//   s        out  combinational sum bit for the current pair
//   carry    out  carry flop; after the MSB it holds the carry-out
// ---------------------------------------------------------------------------
module serial_fa_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic cin_init,
  input  logic a,
  input  logic b,
  output logic s,
  output logic carry
);

  assign s = a ^ b ^ carry;

  // The carry advances every cycle unless preloaded; the owner only reads it
  // while it is feeding real bits, so free-running outside that is harmless.
  always_ff @(posedge clk) begin
    if (!rst_n)
      carry <= 1'b0;
    else if (load)
      carry <= cin_init;
    else
      carry <= (a & b) | (a & carry) | (b & carry);
  end

endmodule

// File: rtl/addsub_serial_checker.sv
// ---------------------------------------------------------------------------
// Module: addsub_serial_checker
// Recomputes A+B or A-B with a bit-serial adder and compares the result
// with the answer a combinational CLA produced for the same vector.
// Optional build macro: ADDSUB_CHK_LOG_EN adds a capture of the first
// failing vector (fail_a, fail_b, fail_op, fail_seen).
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   vector handshake (ready only when idle)
//   a, b, op              operands and operation (0 add, 1 subtract)
//   dut_s, dut_cout       answer under check
//   chk_valid             one-cycle pulse: chk_pass/exp_* are fresh
//   chk_pass              answer matched the recomputed result
//   exp_s, exp_cout       recomputed result, held until the next check
//   err_count             saturating count of failed checks
// ---------------------------------------------------------------------------
module addsub_serial_checker
  import addsub_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 op,
  input  logic [WIDTH-1:0]     dut_s,
  input  logic                 dut_cout,
  output logic                 chk_valid,
  output logic                 chk_pass,
  output logic [WIDTH-1:0]     exp_s,
  output logic                 exp_cout,
  output logic [ERR_CNT_W-1:0] err_count
`ifdef ADDSUB_CHK_LOG_EN
  ,
  output logic [WIDTH-1:0]     fail_a,
  output logic [WIDTH-1:0]     fail_b,
  output logic                 fail_op,
  output logic                 fail_seen
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             op_q;
  logic [WIDTH-1:0] dut_s_q;
  logic             dut_cout_q;
  logic             accept;
  logic             fa_b;
  logic             fa_s;
  logic             fa_carry;
  logic             match;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;

  // Subtraction is A + ~B + 1: invert B bit by bit, the +1 is the carry preload.
  assign fa_b  = b_sh[0] ^ op_q;
  assign match = ({fa_carry, s_sh} == {dut_cout_q, dut_s_q});

  serial_fa_bit u_fa (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .cin_init (op),
    .a        (a_sh[0]),
    .b        (fa_b),
    .s        (fa_s),
    .carry    (fa_carry)
  );

  // Control and datapath. Operands rotate rather than shift so that after
  // WIDTH steps they are back in their original order for the failure log.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      a_sh       <= '0;
      b_sh       <= '0;
      s_sh       <= '0;
      op_q       <= 1'b0;
      dut_s_q    <= '0;
      dut_cout_q <= 1'b0;
      chk_valid  <= 1'b0;
      chk_pass   <= 1'b0;
      exp_s      <= '0;
      exp_cout   <= 1'b0;
      err_count  <= '0;
    end else begin
      chk_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh       <= a;
            b_sh       <= b;
            op_q       <= op;
            dut_s_q    <= dut_s;
            dut_cout_q <= dut_cout;
            bit_cnt    <= '0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          a_sh <= {a_sh[0], a_sh[WIDTH-1:1]};
          b_sh <= {b_sh[0], b_sh[WIDTH-1:1]};
          s_sh <= {fa_s, s_sh[WIDTH-1:1]};
          if (bit_cnt == LAST_BIT)
            state <= CMP;
          else
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
        CMP: begin
          exp_s     <= s_sh;
          exp_cout  <= fa_carry;
          chk_pass  <= match;
          chk_valid <= 1'b1;
          if (!match && (err_count != '1))
            err_count <= err_count + ERR_CNT_W'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ADDSUB_CHK_LOG_EN
  // Only the first failure since reset is kept; later ones are ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fail_a    <= '0;
      fail_b    <= '0;
      fail_op   <= 1'b0;
      fail_seen <= 1'b0;
    end else if ((state == CMP) && !match && !fail_seen) begin
      fail_a    <= a_sh;
      fail_b    <= b_sh;
      fail_op   <= op_q;
      fail_seen <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_addsub_serial_checker.sv
// ---------------------------------------------------------------------------
// Testbench: tb_addsub_serial_checker
// Drives vectors into addsub_serial_checker; each expected result is pushed
// to a scoreboard queue when driven and popped when chk_valid appears.
// Build with ADDSUB_CHK_LOG_EN defined to also check the failure log.
// ---------------------------------------------------------------------------
module tb_addsub_serial_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       op = 1'b0;
  logic [7:0] dut_s = 8'h00;
  logic       dut_cout = 1'b0;
  logic       chk_valid;
  logic       chk_pass;
  logic [7:0] exp_s;
  logic       exp_cout;
  logic [7:0] err_count;
`ifdef ADDSUB_CHK_LOG_EN
  logic [7:0] fail_a;
  logic [7:0] fail_b;
  logic       fail_op;
  logic       fail_seen;
`endif

  typedef struct {
    logic [7:0] s;
    logic       cout;
    logic       pass;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   err_model = 0;

  addsub_serial_checker #(.WIDTH(8), .ERR_CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .dut_s     (dut_s),
    .dut_cout  (dut_cout),
    .chk_valid (chk_valid),
    .chk_pass  (chk_pass),
    .exp_s     (exp_s),
    .exp_cout  (exp_cout),
    .err_count (err_count)
`ifdef ADDSUB_CHK_LOG_EN
    ,
    .fail_a    (fail_a),
    .fail_b    (fail_b),
    .fail_op   (fail_op),
    .fail_seen (fail_seen)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: {cout, s} of A + (op ? ~B : B) + op, 9 bits wide.
  function automatic logic [8:0] ref_result(input logic [7:0] ra, input logic [7:0] rb,
                                            input logic rop);
    logic [7:0] bb;
    bb = rop ? ~rb : rb;
    return {1'b0, ra} + {1'b0, bb} + {8'd0, rop};
  endfunction

  // Called at a negedge; presents the vector for one edge and records what
  // the checker should report for it.
  task automatic drive_vector(input logic [7:0] va, input logic [7:0] vb, input logic vop,
                              input logic [7:0] vs, input logic vc);
    exp_t       e;
    logic [8:0] r;
    a        = va;
    b        = vb;
    op       = vop;
    dut_s    = vs;
    dut_cout = vc;
    in_valid = 1'b1;
    r      = ref_result(va, vb, vop);
    e.s    = r[7:0];
    e.cout = r[8];
    e.pass = ({vc, vs} == r);
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Waits (bounded) for chk_valid; cycles counts negedges since the accept edge.
  task automatic wait_check(input int start, output int cycles, output bit seen);
    cycles = start;
    while (!chk_valid && cycles < 30) begin
      @(negedge clk);
      cycles++;
    end
    seen = chk_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks += 6;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
    if (chk_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_chk_valid got %b want 0", chk_valid); end
    if (chk_pass !== 1'b0) begin errors++; $display("[TB] FAIL reset_chk_pass got %b want 0", chk_pass); end
    if (exp_s !== 8'h00) begin errors++; $display("[TB] FAIL reset_exp_s got %h want 00", exp_s); end
    if (exp_cout !== 1'b0) begin errors++; $display("[TB] FAIL reset_exp_cout got %b want 0", exp_cout); end
    if (err_count !== 8'h00) begin errors++; $display("[TB] FAIL reset_err_count got %h want 00", err_count); end
`ifdef ADDSUB_CHK_LOG_EN
    checks++;
    if (fail_seen !== 1'b0) begin errors++; $display("[TB] FAIL reset_fail_seen got %b want 0", fail_seen); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_sub();
    logic [7:0] ta [0:5] = '{8'h01, 8'h02, 8'h81, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] tb [0:5] = '{8'h01, 8'h03, 8'h81, 8'h01, 8'h00, 8'hFF};
    logic       to [0:5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] ts [0:5] = '{8'h00, 8'h05, 8'h02, 8'h00, 8'hFF, 8'hFE};
    logic       tc [0:5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_t e;
    int   cyc;
    bit   seen;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive_vector(ta[i], tb[i], to[i], ts[i], tc[i]);
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL addsub_busy[%0d] in_ready got %b want 0", i, in_ready); end
      wait_check(1, cyc, seen);
      e = sb.pop_front();
      checks++;
      if (!seen) begin errors++; $display("[TB] FAIL addsub_timeout[%0d] chk_valid got 0 want 1", i); end
      else begin
        checks += 5;
        if (cyc !== 10) begin errors++; $display("[TB] FAIL addsub_latency[%0d] got %0d want 10", i, cyc); end
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL addsub_ready_back[%0d] got %b want 1", i, in_ready); end
        if (exp_s !== e.s) begin errors++; $display("[TB] FAIL addsub_exp_s[%0d] got %h want %h", i, exp_s, e.s); end
        if (exp_cout !== e.cout) begin errors++; $display("[TB] FAIL addsub_exp_cout[%0d] got %b want %b", i, exp_cout, e.cout); end
        if (chk_pass !== e.pass) begin errors++; $display("[TB] FAIL addsub_pass[%0d] got %b want %b", i, chk_pass, e.pass); end
      end
    end
    repeat (3) @(negedge clk);
    checks += 4;
    if (chk_valid !== 1'b0) begin errors++; $display("[TB] FAIL addsub_pulse got %b want 0", chk_valid); end
    if (exp_s !== 8'hFE) begin errors++; $display("[TB] FAIL addsub_hold_s got %h want fe", exp_s); end
    if (exp_cout !== 1'b1) begin errors++; $display("[TB] FAIL addsub_hold_cout got %b want 1", exp_cout); end
    if (err_count !== 8'h00) begin errors++; $display("[TB] FAIL addsub_err_count got %h want 00", err_count); end
  endtask

  task automatic test_mismatch();
    exp_t e;
    int   cyc;
    bit   seen;
    @(negedge clk);
    drive_vector(8'h02, 8'h03, 1'b0, 8'h06, 1'b0);
    wait_check(1, cyc, seen);
    e = sb.pop_front();
    if (seen && !e.pass && err_model < 255) err_model++;
    checks += 4;
    if (!seen) begin errors++; $display("[TB] FAIL mismatch_timeout chk_valid got 0 want 1"); end
    if (chk_pass !== e.pass) begin errors++; $display("[TB] FAIL mismatch_pass got %b want %b", chk_pass, e.pass); end
    if (exp_s !== e.s) begin errors++; $display("[TB] FAIL mismatch_exp_s got %h want %h", exp_s, e.s); end
    if (err_count !== 8'(err_model)) begin errors++; $display("[TB] FAIL mismatch_err_count got %h want %h", err_count, 8'(err_model)); end
    @(negedge clk);
`ifdef ADDSUB_CHK_LOG_EN
    checks += 4;
    if (fail_a !== 8'h02) begin errors++; $display("[TB] FAIL log_fail_a got %h want 02", fail_a); end
    if (fail_b !== 8'h03) begin errors++; $display("[TB] FAIL log_fail_b got %h want 03", fail_b); end
    if (fail_op !== 1'b0) begin errors++; $display("[TB] FAIL log_fail_op got %b want 0", fail_op); end
    if (fail_seen !== 1'b1) begin errors++; $display("[TB] FAIL log_fail_seen got %b want 1", fail_seen); end
`endif
  endtask

  task automatic test_busy_ignore();
    exp_t e;
    int   cyc;
    int   pulses;
    bit   seen;
    @(negedge clk);
    drive_vector(8'h10, 8'h20, 1'b0, 8'h30, 1'b0);
    @(negedge clk);
    // A mismatching vector offered while busy must not be taken.
    a = 8'h55; b = 8'h11; op = 1'b1; dut_s = 8'h00; dut_cout = 1'b0;
    in_valid = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL busy_in_ready got %b want 0", in_ready); end
    in_valid = 1'b0;
    wait_check(7, cyc, seen);
    e = sb.pop_front();
    checks += 3;
    if (!seen || cyc !== 10) begin errors++; $display("[TB] FAIL busy_latency got %0d want 10", cyc); end
    if (chk_pass !== e.pass) begin errors++; $display("[TB] FAIL busy_pass got %b want %b", chk_pass, e.pass); end
    if (exp_s !== e.s) begin errors++; $display("[TB] FAIL busy_exp_s got %h want %h", exp_s, e.s); end
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (chk_valid) pulses++;
    end
    checks += 2;
    if (pulses !== 0) begin errors++; $display("[TB] FAIL busy_extra_check got %0d want 0", pulses); end
    if (err_count !== 8'(err_model)) begin errors++; $display("[TB] FAIL busy_err_count got %h want %h", err_count, 8'(err_model)); end
  endtask

  task automatic test_saturation();
    exp_t       e;
    int         cyc;
    bit         seen;
    logic [7:0] ra, rb;
    logic       rop;
    logic [8:0] r;
    @(negedge clk);
    for (int i = 0; i < 300; i++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rop = 1'($urandom);
      r   = ref_result(ra, rb, rop);
      drive_vector(ra, rb, rop, r[7:0] ^ 8'h01, r[8]);
      wait_check(1, cyc, seen);
      e = sb.pop_front();
      if (seen && !e.pass && err_model < 255) err_model++;
      checks++;
      if (!seen || chk_pass !== e.pass || err_count !== 8'(err_model)) begin
        errors++;
        $display("[TB] FAIL sat[%0d] seen=%b pass=%b err_count=%h want pass=%b err_count=%h",
                 i, seen, chk_pass, err_count, e.pass, 8'(err_model));
      end
    end
    @(negedge clk);
    checks++;
    if (err_count !== 8'hFF) begin errors++; $display("[TB] FAIL sat_final got %h want ff", err_count); end
`ifdef ADDSUB_CHK_LOG_EN
    checks++;
    if (fail_a !== 8'h02 || fail_b !== 8'h03) begin
      errors++; $display("[TB] FAIL log_frozen got %h/%h want 02/03", fail_a, fail_b);
    end
`endif
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   cyc;
    int   pulses;
    bit   seen;
    @(negedge clk);
    drive_vector(8'h3C, 8'h0F, 1'b1, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    void'(sb.pop_back());
    err_model = 0;
    checks += 4;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_in_ready got %b want 1", in_ready); end
    if (chk_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_chk_valid got %b want 0", chk_valid); end
    if (err_count !== 8'h00) begin errors++; $display("[TB] FAIL midrst_err_count got %h want 00", err_count); end
    if (exp_s !== 8'h00) begin errors++; $display("[TB] FAIL midrst_exp_s got %h want 00", exp_s); end
`ifdef ADDSUB_CHK_LOG_EN
    checks++;
    if (fail_seen !== 1'b0) begin errors++; $display("[TB] FAIL midrst_fail_seen got %b want 0", fail_seen); end
`endif
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (chk_valid) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("[TB] FAIL midrst_stale_check got %0d want 0", pulses); end
    drive_vector(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
    wait_check(1, cyc, seen);
    e = sb.pop_front();
    checks += 3;
    if (!seen || cyc !== 10) begin errors++; $display("[TB] FAIL midrst_latency got %0d want 10", cyc); end
    if (chk_pass !== e.pass) begin errors++; $display("[TB] FAIL midrst_pass got %b want %b", chk_pass, e.pass); end
    if (exp_s !== e.s) begin errors++; $display("[TB] FAIL midrst_exp_s_after got %h want %h", exp_s, e.s); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ta [0:3] = '{8'h00, 8'h80, 8'h12, 8'h00};
    logic [7:0] tb [0:3] = '{8'h00, 8'h80, 8'h34, 8'h01};
    logic       to [0:3] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0] ts [0:3] = '{8'h00, 8'h00, 8'hDE, 8'hFF};
    logic       tc [0:3] = '{1'b1, 1'b1, 1'b0, 1'b1};
    exp_t e;
    int   cyc;
    bit   seen;
    @(negedge clk);
    drive_vector(ta[0], tb[0], to[0], ts[0], tc[0]);
    for (int i = 0; i < 4; i++) begin
      wait_check(1, cyc, seen);
      e = sb.pop_front();
      if (seen && !e.pass && err_model < 255) err_model++;
      checks += 5;
      if (!seen || cyc !== 10) begin errors++; $display("[TB] FAIL b2b_latency[%0d] got %0d want 10", i, cyc); end
      if (exp_s !== e.s) begin errors++; $display("[TB] FAIL b2b_exp_s[%0d] got %h want %h", i, exp_s, e.s); end
      if (exp_cout !== e.cout) begin errors++; $display("[TB] FAIL b2b_exp_cout[%0d] got %b want %b", i, exp_cout, e.cout); end
      if (chk_pass !== e.pass) begin errors++; $display("[TB] FAIL b2b_pass[%0d] got %b want %b", i, chk_pass, e.pass); end
      if (err_count !== 8'(err_model)) begin errors++; $display("[TB] FAIL b2b_err_count[%0d] got %h want %h", i, err_count, 8'(err_model)); end
      if (i < 3) begin
        drive_vector(ta[i+1], tb[i+1], to[i+1], ts[i+1], tc[i+1]);
        checks += 2;
        if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_accept[%0d] in_ready got %b want 0", i + 1, in_ready); end
        if (chk_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_pulse[%0d] got %b want 0", i, chk_valid); end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mismatch();
    test_busy_ignore();
    test_saturation();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
